// File: rtl/tinynpu_mac_row.sv
// tinynpu_mac_row
//   Output-stationary row of SIZE signed MAC lanes. One tile pops SIZE operand
//   sets (one activation, SIZE weights) from first-word-fall-through FIFOs and
//   accumulates acc[i] = sum_k x_k * w[i]_k. The SIZE results are then drained
//   one at a time over a valid/ready port, followed by a one-cycle done pulse.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   start    : begin a tile (only looked at while idle)
//   x        : activation FIFO head, signed
//   x_empty  : activation FIFO empty
//   w        : weight FIFO heads, one per lane, signed
//   w_empty  : weight FIFO empty flags, one per lane
//   x_ren    : pop activation FIFO
//   w_ren    : pop every weight FIFO (shared enable)
//   out_val  : result valid
//   out_rdy  : consumer ready
//   out_data : acc[out_idx]
//   out_idx  : lane index of out_data
//   busy     : tile in progress (accumulating or draining)
//   done     : one-cycle pulse after the last result is accepted
module tinynpu_mac_row #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned NBITS = 8,
    parameter int unsigned ABITS = 2*NBITS + $clog2(SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [NBITS-1:0] x,
    input  logic                    x_empty,
    input  logic signed [NBITS-1:0] w [SIZE],
    input  logic                    w_empty [SIZE],
    output logic                    x_ren,
    output logic                    w_ren,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic signed [ABITS-1:0] out_data,
    output logic [$clog2(SIZE)-1:0] out_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned   KW   = $clog2(SIZE);
    localparam logic [KW-1:0] LAST = KW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [ABITS-1:0]   acc      [SIZE];
    logic signed [2*NBITS-1:0] prod     [SIZE];
    logic signed [ABITS-1:0]   prod_ext [SIZE];
    logic [KW-1:0]             k;
    logic [KW-1:0]             idx;

    logic operands_ready;
    logic fire;
    logic clear;
    logic hs;
    logic last_hs;

    // All FIFOs must have data; a partial set is never popped.
    always_comb begin
        operands_ready = !x_empty;
        for (int unsigned i = 0; i < SIZE; i++) begin
            operands_ready = operands_ready && !w_empty[i];
        end
    end

    // Full-width signed products, sign-extended into the accumulator width.
    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            prod[i]     = x * w[i];
            prod_ext[i] = ABITS'(prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pops depend only on registered state and the empty flags, so out_rdy
    // never reaches x_ren/w_ren.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        clear      = 1'b0;
        hs         = 1'b0;
        last_hs    = 1'b0;
        busy       = 1'b0;
        out_val    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                fire = operands_ready;
                if (fire && k == LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                out_val = 1'b1;
                hs      = out_rdy;
                if (hs && idx == LAST) begin
                    last_hs    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        x_ren = fire;
        w_ren = fire;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                acc[i] <= '0;
            end
            k    <= '0;
            idx  <= '0;
            done <= 1'b0;
        end else begin
            done <= last_hs;
            if (clear) begin
                for (int unsigned i = 0; i < SIZE; i++) begin
                    acc[i] <= '0;
                end
                k <= '0;
            end else if (fire) begin
                for (int unsigned i = 0; i < SIZE; i++) begin
                    acc[i] <= acc[i] + prod_ext[i];
                end
                k <= k + 1'b1;
            end
            if (fire && k == LAST) begin
                idx <= '0;
            end else if (last_hs) begin
                idx <= '0;
            end else if (hs) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Outside DRAIN the result port reads zero.
    always_comb begin
        out_data = (state == DRAIN) ? acc[idx] : '0;
        out_idx  = idx;
    end

endmodule

// File: tb/tb_tinynpu_mac_row.sv
// tb_tinynpu_mac_row
//   Directed bench for tinynpu_mac_row (SIZE=4, NBITS=8). The FIFOs are
//   modelled as queues; a tile-level reference model checks every cycle, and
//   directed scenarios pin the drained results and timing with literal values.
module tb_tinynpu_mac_row;

    localparam int SIZE  = 4;
    localparam int NBITS = 8;
    localparam int ABITS = 2*NBITS + $clog2(SIZE);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    start;
    logic signed [NBITS-1:0] x;
    logic                    x_empty;
    logic signed [NBITS-1:0] w [SIZE];
    logic                    w_empty [SIZE];
    logic                    x_ren;
    logic                    w_ren;
    logic                    out_val;
    logic                    out_rdy;
    logic signed [ABITS-1:0] out_data;
    logic [1:0]              out_idx;
    logic                    busy;
    logic                    done;

    tinynpu_mac_row #(
        .SIZE  (SIZE),
        .NBITS (NBITS),
        .ABITS (ABITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .x_empty  (x_empty),
        .w        (w),
        .w_empty  (w_empty),
        .x_ren    (x_ren),
        .w_ren    (w_ren),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents: one activation and one packed weight set per entry.
    logic signed [NBITS-1:0]  xq [$];
    logic [SIZE*NBITS-1:0]    wq [$];
    logic                     pop_pend = 1'b0;

    // Controls applied at the next negedge.
    logic            c_rst    = 1'b0;
    logic            c_start  = 1'b0;
    logic            c_rdy    = 1'b1;
    logic            c_xforce = 1'b0;
    logic [SIZE-1:0] c_wforce = '0;

    // Observations collected by the compare process.
    logic    chk_en    = 1'b0;
    int      cyc       = 0;
    int      pops      = 0;
    int      start_cyc = 0;
    int      done_cyc  = 0;
    logic    done_seen = 1'b0;
    longint  log_i [$];
    longint  log_d [$];

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((longint'(1) << ABITS) - 1);
        if (m >= (longint'(1) << (ABITS - 1))) m = m - (longint'(1) << ABITS);
        return m;
    endfunction

    task automatic push(input logic signed [NBITS-1:0] xv, input logic [SIZE*NBITS-1:0] wv);
        xq.push_back(xv);
        wq.push_back(wv);
    endtask

    // x = 1,2,3,4 ; w[i] = i+1 for every k
    task automatic push_basic();
        for (int k = 0; k < SIZE; k++) push(8'(k + 1), {8'd4, 8'd3, 8'd2, 8'd1});
    endtask

    // One clock: apply staged inputs at negedge, note whether a pop happens,
    // then return after the compare process has sampled this cycle.
    task automatic tick();
        @(negedge clk);
        if (pop_pend && xq.size() != 0) begin
            void'(xq.pop_front());
            void'(wq.pop_front());
        end
        rst     = c_rst;
        start   = c_start;
        out_rdy = c_rdy;
        x       = (xq.size() != 0) ? xq[0] : '0;
        x_empty = (xq.size() == 0) || c_xforce;
        for (int i = 0; i < SIZE; i++) begin
            w[i]       = (wq.size() != 0) ? wq[0][i*NBITS +: NBITS] : '0;
            w_empty[i] = (wq.size() == 0) || c_wforce[i];
        end
        #1 pop_pend = x_ren;
        #2;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done_seen && n < 40) begin
            tick();
            n++;
        end
        if (!done_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 40 cycles", nm);
        end
        done_seen = 1'b0;
    endtask

    task automatic check_log(input string nm, input longint e0, input longint e1,
                             input longint e2, input longint e3);
        longint e [SIZE];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, log_d.size(), SIZE);
        for (int i = 0; i < SIZE; i++) begin
            if (i < log_d.size()) begin
                chk({nm, "_idx"},  log_i[i], i);
                chk({nm, "_data"}, log_d[i], e[i]);
            end
        end
        log_i.delete();
        log_d.delete();
    endtask

    // Reference model: tile phase, operand count, drain pointer, accumulators.
    initial begin : compare
        int     phase;
        int     mk;
        int     midx;
        longint macc [SIZE];
        logic   mdone;
        logic   fire_e;
        phase = 0;
        mk    = 0;
        midx  = 0;
        mdone = 1'b0;
        for (int i = 0; i < SIZE; i++) macc[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            fire_e = (phase == 1) && !x_empty;
            for (int i = 0; i < SIZE; i++) fire_e = fire_e && !w_empty[i];
            if (chk_en) begin
                chk("x_ren",   x_ren,   fire_e);
                chk("w_ren",   w_ren,   fire_e);
                chk("busy",    busy,    phase != 0);
                chk("out_val", out_val, phase == 2);
                chk("done",    done,    mdone);
                if (phase == 2) begin
                    chk("out_idx",  out_idx,  midx);
                    chk("out_data", out_data, macc[midx]);
                end
            end
            if (x_ren === 1'b1) pops++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (rst && out_val && out_rdy) begin
                log_i.push_back(longint'(out_idx));
                log_d.push_back(longint'(out_data));
            end
            if (rst && start && phase == 0) start_cyc = cyc;
            if (!rst) begin
                phase = 0;
                mk    = 0;
                midx  = 0;
                mdone = 1'b0;
                for (int i = 0; i < SIZE; i++) macc[i] = 0;
            end else begin
                mdone = (phase == 2) && out_rdy && (midx == SIZE - 1);
                case (phase)
                    0: if (start) begin
                        phase = 1;
                        mk    = 0;
                        for (int i = 0; i < SIZE; i++) macc[i] = 0;
                    end
                    1: if (fire_e) begin
                        for (int i = 0; i < SIZE; i++)
                            macc[i] = wrap(macc[i] + longint'(x) * longint'(w[i]));
                        mk++;
                        if (mk == SIZE) begin
                            phase = 2;
                            midx  = 0;
                        end
                    end
                    default: if (out_rdy) begin
                        midx++;
                        if (midx == SIZE) begin
                            phase = 0;
                            midx  = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // reset
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx",  out_idx,  0);
        chk("rst_out_val",  out_val,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        c_rst = 1'b1;
        tick();

        // basic tile
        push_basic();
        pops = 0;
        c_start = 1'b1; tick(); c_start = 1'b0;
        wait_done("basic");
        check_log("basic", 10, 20, 30, 40);
        chk("basic_latency", done_cyc - start_cyc, 9);
        chk("basic_pops", pops, 4);

        // signed extremes
        for (int k = 0; k < SIZE; k++) push(-8'sd128, {4{8'h80}});
        c_start = 1'b1; tick(); c_start = 1'b0;
        wait_done("neg_neg");
        check_log("neg_neg", 65536, 65536, 65536, 65536);
        for (int k = 0; k < SIZE; k++) push(-8'sd128, {4{8'h7f}});
        c_start = 1'b1; tick(); c_start = 1'b0;
        wait_done("neg_pos");
        check_log("neg_pos", -65024, -65024, -65024, -65024);

        // w_empty[2] bubbles every other cycle
        push_basic();
        c_start = 1'b1; tick(); c_start = 1'b0;
        for (int n = 0; n < 40 && !done_seen; n++) begin
            c_wforce[2] = ~c_wforce[2];
            tick();
        end
        c_wforce = '0;
        wait_done("wbubble");
        check_log("wbubble", 10, 20, 30, 40);

        // x_empty held for 5 cycles after the first fire
        push_basic();
        pops = 0;
        c_start = 1'b1; tick(); c_start = 1'b0;
        tick();
        c_xforce = 1'b1;
        repeat (5) tick();
        chk("xhold_pops", pops, 1);
        c_xforce = 1'b0;
        wait_done("xhold");
        check_log("xhold", 10, 20, 30, 40);

        // backpressure at idx 1
        push_basic();
        c_start = 1'b1; tick(); c_start = 1'b0;
        repeat (5) tick();
        c_rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_out_val",  out_val,  1);
            chk("bp_out_idx",  out_idx,  1);
            chk("bp_out_data", out_data, 20);
        end
        c_rdy = 1'b1;
        wait_done("bp");
        check_log("bp", 10, 20, 30, 40);
        chk("bp_latency", done_cyc - start_cyc, 12);

        // start pulses mid-ACCUM and mid-DRAIN are ignored
        push_basic();
        c_start = 1'b1; tick(); c_start = 1'b0;
        tick();
        c_start = 1'b1; tick(); c_start = 1'b0;
        repeat (3) tick();
        c_start = 1'b1; tick(); c_start = 1'b0;
        wait_done("midstart");
        check_log("midstart", 10, 20, 30, 40);
        chk("midstart_latency", done_cyc - start_cyc, 9);

        // reset after two fires, then a clean tile
        for (int k = 0; k < SIZE; k++) push(8'sd100, {4{8'd100}});
        c_start = 1'b1; tick(); c_start = 1'b0;
        repeat (2) tick();
        c_rst = 1'b0; tick(); c_rst = 1'b1;
        xq.delete();
        wq.delete();
        pop_pend = 1'b0;
        tick();
        chk("abort_out_data", out_data, 0);
        chk("abort_out_idx",  out_idx,  0);
        chk("abort_out_val",  out_val,  0);
        chk("abort_busy",     busy,     0);
        chk("abort_x_ren",    x_ren,    0);
        log_i.delete();
        log_d.delete();
        push_basic();
        c_start = 1'b1; tick(); c_start = 1'b0;
        wait_done("after_rst");
        check_log("after_rst", 10, 20, 30, 40);

        // back-to-back tiles, second start in the done cycle
        push_basic();
        for (int k = 0; k < SIZE; k++) push(8'sd2, {4{8'd3}});
        c_start = 1'b1; tick(); c_start = 1'b0;
        repeat (8) tick();
        c_start = 1'b1; tick(); c_start = 1'b0;
        chk("b2b_done_pulse", done, 1);
        done_seen = 1'b0;
        check_log("b2b_first", 10, 20, 30, 40);
        tick();
        chk("b2b_no_gap_busy", busy, 1);
        wait_done("b2b_second");
        check_log("b2b_second", 24, 24, 24, 24);
        chk("b2b_latency", done_cyc - start_cyc, 9);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tinynpu_mac_row.md
# tinynpu_mac_row

Consumes the operand streams produced by the TinyNPU input/weight datapath: one activation FIFO head `x` and `SIZE` weight FIFO heads `w[i]`. For one tile it pops `SIZE` operand sets and accumulates `SIZE` signed dot products, `acc[i] = sum_k x_k * w[i]_k`, in an output-stationary row of MACs. It then drains the results serially through a valid/ready port. It sits directly downstream of the datapath FIFOs and drives their shared read enables.

## Interface

Parameters:
- `SIZE`, 4: number of MAC lanes and tile depth (k = 0..SIZE-1); power of two, at least 2.
- `NBITS`, 8: operand width, signed two's complement.
- `ABITS`, 2*NBITS+$clog2(SIZE): accumulator and result width, signed.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-low (`rst==0` resets at the edge).
- `start`, in, 1: begin a tile; sampled only in IDLE.
- `x`, in, NBITS: activation FIFO head (first-word-fall-through).
- `x_empty`, in, 1: activation FIFO empty.
- `w`, in, NBITS [SIZE]: weight FIFO heads.
- `w_empty`, in, 1 [SIZE]: weight FIFO empty flags.
- `x_ren`, out, 1: pop activation FIFO.
- `w_ren`, out, 1: pop all weight FIFOs; the enable is shared.
- `out_val`, out, 1: result valid.
- `out_rdy`, in, 1: consumer ready.
- `out_data`, out, ABITS: result `acc[out_idx]`.
- `out_idx`, out, $clog2(SIZE): lane index of `out_data`.
- `busy`, out, 1: high in ACCUM or DRAIN.
- `done`, out, 1: one-cycle pulse after the last result is accepted.

## Operation

States:
- IDLE: waits for `start`. On `start==1` it clears all `acc[i]` to 0, sets `k` to 0 and moves to ACCUM.
- ACCUM:
  - `fire = !x_empty && !w_empty[0] && ... && !w_empty[SIZE-1]`.
  - `x_ren = w_ren = fire`, combinationally.
  - On fire: `acc[i] <= acc[i] + sext(x*w[i])` for every lane, and `k <= k+1`.
  - A fire with `k==SIZE-1` moves to DRAIN with `idx=0`.
  - Without a fire the block holds all state. An empty FIFO is never popped.
- DRAIN:
  - `out_val=1`, `out_data=acc[idx]`, `out_idx=idx`.
  - On `out_val && out_rdy`: `idx <= idx+1`.
  - The handshake at `idx==SIZE-1` returns to IDLE and pulses `done` in the following cycle.

Arithmetic:
- Products are full 2*NBITS signed and sign-extended to ABITS.
- Accumulation wraps modulo 2^ABITS. There is no saturation and no overflow flag.

Boundary rules:
- `start` outside IDLE is ignored. A `start` in the same cycle `done` is high is accepted, so back-to-back tiles are allowed.
- `x_ren` and `w_ren` are 0 in IDLE and DRAIN, whatever the FIFO state.
- If only some FIFOs are non-empty, nothing is popped.
- `out_data` and `out_idx` stay stable while `out_val && !out_rdy`.
- Reset in any state:
  - The block returns to IDLE and clears `acc`, `k` and `idx`.
  - Operands already popped are lost and no partial results are emitted.

## Timing

- Reset values: `x_ren=0`, `w_ren=0`, `out_val=0`, `out_data=0`, `out_idx=0`, `busy=0`, `done=0`.
- `start` at edge T: `busy=1` from T+1, and the first fire is possible in cycle T+1.
- Each fire takes one cycle. The last fire at cycle F gives `out_val=1` from F+1.
- With no bubbles and `out_rdy=1`, a tile takes 1 + SIZE + SIZE cycles from `start` to the `done` pulse (9 for SIZE=4).
- `done` is high for exactly one cycle, in IDLE, with `busy=0`.
- Pop outputs are combinational from registered state and the empty flags. There is no combinational path from `out_rdy` to `x_ren` or `w_ren`.

## Test plan

- **Basic tile.** SIZE=4. Activation stream x = 1,2,3,4; weight stream `w[i]_k = i+1` for every k; `out_rdy=1`. Required: outputs (idx,data) = (0,10), (1,20), (2,30), (3,40), `done` at cycle 9, exactly 4 `x_ren` pulses.
- **Signed extremes.** x = -128 and w[i] = -128 for all four k. Required: every result is 65536. Repeat with w = 127: every result is -65024.
- **Bubbles.**
  - Deassert `w_empty[2]` only every other cycle during ACCUM. Required: pops happen only when all FIFOs are non-empty, and results match the basic tile.
  - Hold `x_empty=1` for 5 cycles. Required: no pop and `acc` unchanged.
- **Backpressure.** Basic tile with `out_rdy` low for 3 cycles at idx=1. Required: `out_data=20` and `out_idx=1` held stable; full sequence still 10,20,30,40; `done` delayed by 3 cycles.
- **Start and reset robustness.**
  - Pulse `start` mid-ACCUM and mid-DRAIN. Required: ignored.
  - Assert `rst=0` after 2 fires. Required: all outputs at reset values next cycle; a new tile then gives correct results, with no residue from the aborted one.
- **Back-to-back tiles.** Assert `start` in the `done` cycle with new data x=2 and w=3. Required: second tile results are all 24, with no idle gap.
